// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic modes and a
// level interrupt cleared by an acknowledge strobe.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no load yet, or last load was zero
// RUN   | counting down (paused while enable = 0)
// DONE  | one-shot expired; waits for a new load
module countdown_timer #(
   parameter int WIDTH = 32,
   parameter int PW    = 16,
   parameter int EW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [PW-1:0]    prescale,
   input  logic             enable,
   input  logic             auto_reload,
   input  logic             irq_ack,
   output logic [WIDTH-1:0] count,
   output logic             irq,
   output logic             running,
   output logic [EW-1:0]    expire_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n, reload, reload_n;
   logic [PW-1:0]    pcnt, pcnt_n;
   logic             irq_n;
   logic [EW-1:0]    expire_cnt_n;
   logic             expire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload     <= '0;
         pcnt       <= '0;
         irq        <= 1'b0;
         expire_cnt <= '0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload     <= reload_n;
         pcnt       <= pcnt_n;
         irq        <= irq_n;
         expire_cnt <= expire_cnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      count_n      = count;
      reload_n     = reload;
      pcnt_n       = pcnt;
      expire       = 1'b0;

      if (load) begin
         // a tick landing on the load cycle is dropped
         count_n  = load_val;
         reload_n = load_val;
         pcnt_n   = '0;
         state_n  = (load_val != '0) ? RUN : IDLE;
      end else if (state == RUN && enable) begin
         if (pcnt >= prescale) begin
            pcnt_n = '0;
            if (count > WIDTH'(1)) begin
               count_n = count - 1'b1;
            end else begin
               expire = 1'b1;
               if (auto_reload) begin
                  count_n = reload;
               end else begin
                  count_n = '0;
                  state_n = DONE;
               end
            end
         end else begin
            pcnt_n = pcnt + 1'b1;
         end
      end

      // set has priority over acknowledge
      if (expire)
         irq_n = 1'b1;
      else if (irq_ack)
         irq_n = 1'b0;
      else
         irq_n = irq;

      if (expire && expire_cnt != '1)
         expire_cnt_n = expire_cnt + 1'b1;
      else
         expire_cnt_n = expire_cnt;
   end

   assign running = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a per-cycle vector table plus hand
// sequences for auto-reload, held acknowledge, saturation and reset mid-run.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rst, load, enable, auto_reload, irq_ack;
   logic [31:0] load_val;
   logic [15:0] prescale;
   logic [31:0] count;
   logic        irq, running;
   logic [7:0]  expire_cnt;

   int checks   = 0;
   int failures = 0;

   countdown_timer #(.WIDTH(32), .PW(16), .EW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .prescale    (prescale),
      .enable      (enable),
      .auto_reload (auto_reload),
      .irq_ack     (irq_ack),
      .count       (count),
      .irq         (irq),
      .running     (running),
      .expire_cnt  (expire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, load;
      logic [31:0] load_val;
      logic [15:0] prescale;
      logic        enable, auto_reload, irq_ack;
      logic [31:0] e_count;
      logic        e_irq, e_running;
      logic [7:0]  e_exp;
   } vec_t;

   localparam int NV = 30;
   vec_t vecs [NV];

   function automatic vec_t v(input logic r, input logic ld, input int lv, input int ps,
                              input logic en, input logic ar, input logic ack,
                              input int c, input logic i, input logic rn, input int e);
      vec_t x;
      x.rst = r;  x.load = ld; x.load_val = 32'(lv); x.prescale = 16'(ps);
      x.enable = en; x.auto_reload = ar; x.irq_ack = ack;
      x.e_count = 32'(c); x.e_irq = i; x.e_running = rn; x.e_exp = 8'(e);
      return x;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic ld, input int lv, input int ps,
                        input logic en, input logic ar, input logic ack);
      rst = r; load = ld; load_val = 32'(lv); prescale = 16'(ps);
      enable = en; auto_reload = ar; irq_ack = ack;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);

      //              rst ld val ps en ar ack   count irq run exp
      vecs[0]  = v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
      vecs[1]  = v(0, 1, 3, 0, 1, 0, 0,   3, 0, 1, 0);
      vecs[2]  = v(0, 0, 0, 0, 1, 0, 0,   2, 0, 1, 0);
      vecs[3]  = v(0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0);
      vecs[4]  = v(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 1);
      vecs[5]  = v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
      vecs[6]  = v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
      vecs[7]  = v(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 1);
      vecs[8]  = v(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
      vecs[9]  = v(0, 1, 2, 0, 1, 0, 0,   2, 0, 1, 1);
      vecs[10] = v(0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 1);
      vecs[11] = v(0, 1, 5, 0, 1, 0, 0,   5, 0, 1, 1);
      vecs[12] = v(0, 0, 0, 0, 1, 0, 0,   4, 0, 1, 1);
      // prescale 2, load 2, four-cycle pause: expiry 10 edges after load
      vecs[13] = v(0, 1, 2, 2, 1, 0, 0,   2, 0, 1, 1);
      vecs[14] = v(0, 0, 0, 2, 1, 0, 0,   2, 0, 1, 1);
      vecs[15] = v(0, 0, 0, 2, 1, 0, 0,   2, 0, 1, 1);
      vecs[16] = v(0, 0, 0, 2, 1, 0, 0,   1, 0, 1, 1);
      vecs[17] = v(0, 0, 0, 2, 0, 0, 0,   1, 0, 1, 1);
      vecs[18] = v(0, 0, 0, 2, 0, 0, 0,   1, 0, 1, 1);
      vecs[19] = v(0, 0, 0, 2, 0, 0, 0,   1, 0, 1, 1);
      vecs[20] = v(0, 0, 0, 2, 0, 0, 0,   1, 0, 1, 1);
      vecs[21] = v(0, 0, 0, 2, 1, 0, 0,   1, 0, 1, 1);
      vecs[22] = v(0, 0, 0, 2, 1, 0, 0,   1, 0, 1, 1);
      vecs[23] = v(0, 0, 0, 2, 1, 0, 0,   0, 1, 0, 2);
      vecs[24] = v(0, 0, 0, 2, 1, 0, 1,   0, 0, 0, 2);
      // lowering prescale below the running prescale count ticks at once
      vecs[25] = v(0, 1, 3, 5, 1, 0, 0,   3, 0, 1, 2);
      vecs[26] = v(0, 0, 0, 5, 1, 0, 0,   3, 0, 1, 2);
      vecs[27] = v(0, 0, 0, 5, 1, 0, 0,   3, 0, 1, 2);
      vecs[28] = v(0, 0, 0, 1, 1, 0, 0,   2, 0, 1, 2);
      vecs[29] = v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].load, int'(vecs[i].load_val), int'(vecs[i].prescale),
               vecs[i].enable, vecs[i].auto_reload, vecs[i].irq_ack);
         step();
         chk("vec_count",   i, count,              vecs[i].e_count);
         chk("vec_irq",     i, 32'(irq),           32'(vecs[i].e_irq));
         chk("vec_running", i, 32'(running),       32'(vecs[i].e_running));
         chk("vec_expire",  i, 32'(expire_cnt),    32'(vecs[i].e_exp));
      end

      // auto-reload period 4, ack one cycle after each irq
      drive(0, 1, 4, 0, 1, 1, 0);
      step();
      chk("ar_load_count", 0, count, 32'd4);
      for (int i = 1; i <= 12; i++) begin
         drive(0, 0, 0, 0, 1, 1, (i % 4) == 1);
         step();
         chk("ar_count",  i, count,            32'(4 - (i % 4)));
         chk("ar_irq",    i, 32'(irq),         32'((i % 4) == 0));
         chk("ar_expire", i, 32'(expire_cnt),  32'(i / 4));
      end

      // load 1 periodic with ack held: irq stays set; 260 expirations saturate
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 1, 1, 0, 1, 1, 1);
      step();
      chk("hold_load_irq", 0, 32'(irq), 32'd0);
      for (int i = 1; i <= 260; i++) begin
         drive(0, 0, 0, 0, 1, 1, 1);
         step();
         if (i <= 4 || i == 254 || i == 255 || i == 256) begin
            chk("hold_irq",    i, 32'(irq),        32'd1);
            chk("hold_expire", i, 32'(expire_cnt), 32'(i > 255 ? 255 : i));
         end
      end
      chk("sat_expire", 260, 32'(expire_cnt), 32'd255);
      chk("sat_count",  260, count,           32'd1);

      // reset mid-run with irq=1, count=7, expire_cnt=3
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 1, 1, 0, 1, 1, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 1, 1, 0);
         step();
      end
      drive(0, 1, 7, 0, 1, 1, 0);
      step();
      chk("pre_rst_count",  0, count,            32'd7);
      chk("pre_rst_irq",    0, 32'(irq),         32'd1);
      chk("pre_rst_expire", 0, 32'(expire_cnt),  32'd3);
      drive(1, 0, 0, 0, 1, 1, 0);
      step();
      chk("rst_count",   0, count,            32'd0);
      chk("rst_irq",     0, 32'(irq),         32'd0);
      chk("rst_running", 0, 32'(running),     32'd0);
      chk("rst_expire",  0, 32'(expire_cnt),  32'd0);
      drive(0, 0, 0, 0, 1, 1, 0);
      step();
      chk("post_rst_count", 0, count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer with prescaler, one-shot/auto-reload modes and a level interrupt with acknowledge handshake. It is the counterpart of the free-running up-counter used for cycle statistics in the single-cycle CPU. Software-visible control (load, enable, mode) arrives from the CPU's I/O decode. `irq` feeds the interrupt input of the CPU.

## Interface

Parameters:
- `WIDTH`, 32, width of count and reload value
- `PW`, 16, width of prescale value
- `EW`, 8, width of saturating expiration counter

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `load`  in  1  one-cycle strobe: capture `load_val` into reload register and count
- `load_val`  in  WIDTH  initial/reload value in ticks
- `prescale`  in  PW  tick period minus one; one tick every `prescale`+1 enabled cycles
- `enable`  in  1  1 = counting, 0 = pause (all counters frozen)
- `auto_reload`  in  1  1 = periodic, 0 = one-shot
- `irq_ack`  in  1  clears `irq`
- `count`  out  WIDTH  current remaining ticks
- `irq`  out  1  expiration pending
- `running`  out  1  state == RUN
- `expire_cnt`  out  EW  number of expirations since reset, saturates at 2^EW-1

## Operation

- States:
  - IDLE: no load yet, or loaded with 0.
  - RUN: counting down.
  - DONE: one-shot finished.
- Reset values:
  - `count`=0, reload register=0, prescale counter=0.
  - State IDLE, so `running`=0.
  - `irq`=0, `expire_cnt`=0.
- Load, accepted in any state:
  - `count` and reload register take `load_val`; prescale counter clears to 0.
  - Next state is RUN if `load_val`≠0, else IDLE.
  - `irq` and `expire_cnt` are unaffected.
  - Load has priority over a same-cycle tick; that tick is discarded.
- Prescaler, in RUN with `enable`=1 only:
  - If prescale counter ≥ `prescale`, it clears to 0 and a tick is issued.
  - Otherwise it increments.
  - Using ≥ means lowering `prescale` mid-run ticks on the next enabled cycle.
- Tick in RUN:
  - If `count`>1: `count` decrements.
  - If `count`==1, expiration:
    - `irq` is set.
    - `expire_cnt` increments unless saturated.
    - If `auto_reload`=1: `count` takes the reload register and state stays RUN.
    - Else: `count`=0 and next state is DONE.
- `auto_reload` is sampled at the expiring tick; changing it mid-count has no other effect.
- IDLE and DONE: `count` holds and the prescaler holds at 0; only `load` leaves these states.
- `enable`=0 in RUN: `count` and the prescale counter hold; state stays RUN, so `running`=1.
- Interrupt:
  - `irq` stays high until a cycle with `irq_ack`=1.
  - If expiration and `irq_ack` occur in the same cycle, `irq` stays 1 (set wins).
  - `irq_ack` while `irq`=0 has no effect.
- `rst` mid-run: all outputs return to reset values on that edge; any pending `irq` is lost.

## Timing

- All outputs are registered; no combinational input-to-output paths.
- Load at edge E: `count`=`load_val` and `running`=1 visible after E.
- Expiry latency, with `enable` held high: `irq` rises at edge E + `load_val`×(`prescale`+1).
  - Example: `load_val`=3, `prescale`=0 gives `irq`=1 after E+3.
- Auto-reload period: `load_val`×(`prescale`+1) cycles between `irq` rising events, when acked in between.
- `irq` falls on the edge that samples `irq_ack`=1, one cycle latency.
- Pausing for k cycles delays expiry by exactly k cycles.

## Test plan

1. Reset, then one-shot with `prescale`=0: load 3, `enable`=1.
   - Required: `count` 3,2,1,0 on successive edges.
   - Required: `irq`=1 and `running`=0 after the third edge; `expire_cnt`=1.
2. Prescale and pause: `prescale`=2, load 2, then drop `enable` for 4 cycles mid-count.
   - Required: `irq` rises exactly 6+4=10 cycles after load.
   - Required: `count` holds during the pause.
3. Auto-reload: load 4, `prescale`=0, `auto_reload`=1, `irq_ack` pulsed 1 cycle after each `irq`.
   - Required: `irq` rises every 4 cycles.
   - Required: `count` sequence 4,3,2,1,4,3…; `expire_cnt` increments each period.
4. Interrupt edge cases:
   - Periodic with load 1: `irq_ack` held high continuously keeps `irq`=1, because set beats ack.
   - `irq_ack` with `irq`=0 leaves `irq` at 0.
5. Load priority and zero load:
   - Load 5 on the same cycle a tick would expire: required `count`=5, no `irq`.
   - Load 0: required state IDLE, `running`=0, `count` 0, no `irq` ever.
6. Reset mid-run with `irq`=1, `count`=7, `expire_cnt`=3: the `rst` edge returns all outputs to 0.
   - Saturation check: 260 expirations with `EW`=8 leave `expire_cnt`=255.
